// File: rtl/commu_head_if.sv
// Header-transmitter handshake bundle: start strobe and config in, serial line and status out.
`timescale 1ns/1ps
interface commu_head_if;
  logic        fire_head;
  logic        done_head;
  logic [7:0]  cfg_id;
  logic [15:0] cfg_len;
  logic        tx_head;
  logic        busy_head;

  modport master (output fire_head, cfg_id, cfg_len, input done_head, tx_head, busy_head);
  modport slave  (input fire_head, cfg_id, cfg_len, output done_head, tx_head, busy_head);
endinterface

// File: rtl/commu_head.sv
// Sends the 5-byte frame header EB 90 id len_hi len_lo as UART 8N1; done 1+50*BAUD_DIV cycles after fire.
// No backpressure: fire_head is accepted only in S_IDLE and ignored otherwise.
`timescale 1ns/1ps
module commu_head #(
  parameter logic [15:0] BAUD_DIV = 16'd868
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  commu_head_if.slave  hd
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [2:0]  byte_cnt, byte_nxt;
  logic [7:0]  id_q;
  logic [15:0] len_q;
  logic        tx_q, tx_nxt;
  logic        bit_end;
  logic [7:0]  byte_cur;

  assign bit_end = (baud_cnt == BAUD_DIV - 16'd1);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
      byte_cnt <= 3'd0;
      id_q     <= 8'd0;
      len_q    <= 16'd0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      tx_q     <= tx_nxt;
      if (state == S_IDLE && hd.fire_head) begin
        id_q  <= hd.cfg_id;
        len_q <= hd.cfg_len;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 16'd1;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    case (state)
      S_IDLE: begin
        baud_nxt = 16'd0;
        bit_nxt  = 3'd0;
        byte_nxt = 3'd0;
        if (hd.fire_head) state_nxt = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_nxt  = 16'd0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_nxt = 16'd0;
          bit_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_nxt = 16'd0;
          if (byte_cnt == 3'd4) begin
            byte_nxt  = 3'd0;
            state_nxt = S_DONE;
          end else begin
            byte_nxt  = byte_cnt + 3'd1;
            state_nxt = S_START;
          end
        end
      end
      S_DONE: begin
        baud_nxt  = 16'd0;
        bit_nxt   = 3'd0;
        byte_nxt  = 3'd0;
        state_nxt = S_IDLE;
      end
      default: begin
        baud_nxt  = 16'd0;
        bit_nxt   = 3'd0;
        byte_nxt  = 3'd0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // tx is registered from next-state values so the start bit lands on the cycle right after fire.
  always_comb begin
    case (byte_nxt)
      3'd0:    byte_cur = 8'hEB;
      3'd1:    byte_cur = 8'h90;
      3'd2:    byte_cur = id_q;
      3'd3:    byte_cur = len_q[15:8];
      default: byte_cur = len_q[7:0];
    endcase
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = byte_cur[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
    hd.done_head = (state == S_DONE);
    hd.busy_head = (state != S_IDLE);
    hd.tx_head   = tx_q;
  end

endmodule

// File: tb/tb_commu_head.sv
// Directed bench for commu_head at BAUD_DIV=4: vector table of headers plus busy/config/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_commu_head;

  localparam logic [15:0] BD = 16'd4;
  localparam int NB = 300;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  commu_head_if hif();

  commu_head #(.BAUD_DIV(BD)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .hd      (hif.slave)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] len;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;
  logic tx_log[NB];
  logic busy_log[NB];
  logic done_log[NB];
  int   fire_k1 = -1;
  int   fire_k2 = -1;
  int   chg_k   = -1;
  int   rst_k   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; fire is sampled at the next posedge (cycle 0), then ncyc negedge samples are logged.
  task automatic capture(input logic [7:0] id, input logic [15:0] len, input int ncyc);
    hif.cfg_id    = id;
    hif.cfg_len   = len;
    hif.fire_head = 1'b1;
    @(posedge clk_sys);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_sys);
      tx_log[k]   = hif.tx_head;
      busy_log[k] = hif.busy_head;
      done_log[k] = hif.done_head;
      hif.fire_head = (k == fire_k1 || k == fire_k2);
      if (k == chg_k) hif.cfg_id = 8'hAA;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", 64'(hif.tx_head), 64'd1);
        chk("midrst_busy", 64'(hif.busy_head), 64'd0);
        chk("midrst_done", 64'(hif.done_head), 64'd0);
      end
      if (rst_k >= 0 && k == rst_k + 2) rst_n = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp, input int ncyc);
    logic [39:0] got;
    logic        width_ok;
    logic        idle_ok;
    logic        v;
    int          done_cnt;
    int          done_pos;
    int          busy_cnt;
    int          base;
    got      = 40'd0;
    width_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      base = b * 40;
      for (int j = 0; j < 4; j++) begin
        if (tx_log[base + j] !== 1'b0) width_ok = 1'b0;
        if (tx_log[base + 36 + j] !== 1'b1) width_ok = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        v = tx_log[base + 4 + 4 * i];
        for (int j = 1; j < 4; j++)
          if (tx_log[base + 4 + 4 * i + j] !== v) width_ok = 1'b0;
        got[32 - 8 * b + i] = v;
      end
      chk($sformatf("%s_byte%0d", tag, b), 64'(got[39 - 8 * b -: 8]), 64'(exp[39 - 8 * b -: 8]));
    end
    done_cnt = 0;
    done_pos = -1;
    busy_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (done_log[k] === 1'b1) begin
        done_cnt++;
        if (done_pos < 0) done_pos = k;
      end
      if (busy_log[k] === 1'b1) busy_cnt++;
    end
    chk($sformatf("%s_bit_widths", tag), 64'(width_ok), 64'd1);
    chk($sformatf("%s_done_pos", tag), 64'(done_pos), 64'd200);
    chk($sformatf("%s_done_cnt", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s_busy_cnt", tag), 64'(busy_cnt), 64'd201);
    if (ncyc > 201) begin
      idle_ok = 1'b1;
      for (int k = 201; k < ncyc; k++)
        if (tx_log[k] !== 1'b1 || busy_log[k] !== 1'b0) idle_ok = 1'b0;
      chk($sformatf("%s_idle_after", tag), 64'(idle_ok), 64'd1);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int done_cnt;

    vecs[0] = '{8'h05, 16'h0123, 40'hEB_90_05_01_23};
    vecs[1] = '{8'h00, 16'h0000, 40'hEB_90_00_00_00};
    vecs[2] = '{8'hFF, 16'hFFFF, 40'hEB_90_FF_FF_FF};
    vecs[3] = '{8'h5A, 16'hA55A, 40'hEB_90_5A_A5_5A};

    hif.fire_head = 1'b0;
    hif.cfg_id    = 8'h00;
    hif.cfg_len   = 16'h0000;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset_tx", 64'(hif.tx_head), 64'd1);
    chk("reset_busy", 64'(hif.busy_head), 64'd0);
    chk("reset_done", 64'(hif.done_head), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);

    for (int v = 0; v < 4; v++) begin
      capture(vecs[v].id, vecs[v].len, 230);
      check_frame($sformatf("vec%0d", v), vecs[v].exp, 230);
    end
    chk("start_last_cycle", 64'(tx_log[3]), 64'd0);
    chk("lsb_after_start", 64'(tx_log[4]), 64'd1);

    fire_k1 = 10;
    fire_k2 = 200;
    capture(8'h05, 16'h0123, 230);
    check_frame("busyfire", 40'hEB_90_05_01_23, 230);
    fire_k1 = -1;
    fire_k2 = -1;

    chg_k = 0;
    capture(8'h05, 16'h0123, 230);
    check_frame("cfgchg", 40'hEB_90_05_01_23, 230);
    chg_k = -1;

    rst_k = 90;
    capture(8'h05, 16'h0123, 150);
    rst_k = -1;
    done_cnt = 0;
    for (int k = 0; k < 150; k++)
      if (done_log[k] === 1'b1) done_cnt++;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle_busy", 64'(busy_log[149]), 64'd0);
    chk("midrst_idle_tx", 64'(tx_log[149]), 64'd1);
    capture(vecs[3].id, vecs[3].len, 230);
    check_frame("postrst", vecs[3].exp, 230);

    capture(8'h11, 16'h2233, 201);
    check_frame("b2b_a", 40'hEB_90_11_22_33, 201);
    @(negedge clk_sys);
    chk("b2b_gap_tx", 64'(hif.tx_head), 64'd1);
    chk("b2b_gap_busy", 64'(hif.busy_head), 64'd0);
    capture(8'h22, 16'h4455, 230);
    check_frame("b2b_b", 40'hEB_90_22_44_55, 230);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commu_head.md
COMMU_HEAD -- requirements
Module: commu_head

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 16'd868, meaning clk_sys cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port clk_sys, input, 1, system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; one clock, asynchronous assert, active-low.
REQ-004 The block SHALL have port fire_head, input, 1, single-cycle start strobe from commu_main.
REQ-005 The block SHALL have port done_head, output, 1, single-cycle completion strobe back to commu_main.
REQ-006 The block SHALL have port cfg_id, input, 8, node ID placed in the header.
REQ-007 The block SHALL have port cfg_len, input, 16, payload length placed in the header.
REQ-008 The block SHALL have port tx_head, output, 1, serial line (UART 8N1, LSB first, idle high).
REQ-009 The block SHALL have port busy_head, output, 1, high whenever the FSM is not in S_IDLE.

Function
REQ-010 The header SHALL be exactly 5 bytes in order: 0xEB, 0x90, cfg_id, cfg_len[15:8], cfg_len[7:0].
REQ-011 cfg_id and cfg_len SHALL be captured on the clock edge that samples fire_head high; later changes SHALL NOT affect the frame in progress.
REQ-012 FSM states SHALL be S_IDLE, S_START, S_DATA, S_STOP, S_DONE.
REQ-013 Transitions SHALL be: S_IDLE->S_START on fire_head; S_START->S_DATA after BAUD_DIV cycles; S_DATA->S_STOP after 8 bits; S_STOP->S_START after BAUD_DIV cycles if bytes remain, else ->S_DONE; S_DONE->S_IDLE unconditionally after 1 cycle.
REQ-014 tx_head SHALL be registered: 0 in S_START, the current data bit in S_DATA, and 1 in S_STOP, S_DONE and S_IDLE.
REQ-015 Each bit (start, data, stop) SHALL last exactly BAUD_DIV cycles, with no idle gap between bytes.
REQ-016 The start bit of byte 0 SHALL begin on the cycle immediately after the fire_head sample cycle.
REQ-017 done_head SHALL be high for exactly one cycle (state S_DONE), starting 1 + 50*BAUD_DIV cycles after the fire_head sample cycle.
REQ-018 The baud counter SHALL be 16 bits, count 0..BAUD_DIV-1, and reset to 0 on every bit boundary; the bit counter SHALL be 3 bits and the byte counter 3 bits (0..4).
REQ-019 fire_head asserted while busy_head=1 (including S_DONE) SHALL be ignored, with no restart, queueing or effect on the current frame.
REQ-020 fire_head held high for several cycles SHALL start only one frame; a new frame requires fire_head high while in S_IDLE.

Reset
REQ-021 On rst_n low, the FSM SHALL enter S_IDLE with tx_head=1, done_head=0, busy_head=0, all counters=0 and the captured fields=0, regardless of the frame in progress.
REQ-022 Reset mid-frame SHALL abort the frame without asserting done_head; the line SHALL return high within the reset-assert cycle.

Verification (BAUD_DIV=4)
REQ-023 Single frame: cfg_id=0x05, cfg_len=0x0123, fire_head pulse -> decoded bytes EB 90 05 01 23; done_head pulse exactly 201 cycles after the fire cycle; busy_head high for 201 cycles.
REQ-024 Bit timing: check every start, data and stop bit is 4 cycles wide, the LSB of 0xEB (=1) follows the start bit, and there is no gap between stop bit and next start bit.
REQ-025 Busy fire: extra fire_head at cycles 10 and 200 of a frame -> single frame and a single done_head; tx_head stays high after done_head.
REQ-026 Config change: cfg_id changed to 0xAA one cycle after fire_head -> third byte is still 0x05.
REQ-027 Mid-frame reset: assert rst_n low during byte 2 -> tx_head=1 and busy_head=0 immediately, no done_head; a new fire after release -> complete correct frame.
REQ-028 Back-to-back frames: fire_head issued the cycle after done_head -> second frame starts correctly, with a 1-cycle idle-high gap.
